// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers: the fp32 field view, canonical constants and the
// NaN classifier used by the reduction blocks.
// Purely declarative; no logic or state is instantiated here.
package fpu_pkg;

    // IEEE-754 single-precision field view.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

    // Reducer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fmax_state_t;

    // Any non-zero mantissa under an all-ones exponent is a NaN.
    function automatic logic fp32_is_nan(input fp32_t v);
        return (v.exp == FP32_EXP_MAX) && (v.man != 23'd0);
    endfunction

endpackage

// File: rtl/fmax_cmp.sv
// Combinational fp32 ordering comparator: a_ge_b=1 when a should be kept over b.
// Ports: a (incumbent/accumulator), b (challenger), a_ge_b (keep a).
// Zero-latency, no state; ties keep a; ZERO_POS_WINS decides +0.0 vs -0.0.
module fmax_cmp
#(
    parameter int ZERO_POS_WINS = 1
)
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_ge_b
);

    logic        sign_a;
    logic        sign_b;
    logic [30:0] mag_a;
    logic [30:0] mag_b;
    logic        both_zero;

    assign sign_a    = a[31];
    assign sign_b    = b[31];
    assign mag_a     = a[30:0];
    assign mag_b     = b[30:0];
    assign both_zero = (mag_a == 31'd0) && (mag_b == 31'd0);

    // {exp,man} is monotonic in magnitude for every class (denormal, normal,
    // inf, NaN), so the raw 31-bit field serves as the magnitude key.
    always_comb begin
        a_ge_b = 1'b1;
        if (both_zero) begin
            // Only a sign difference can matter between two zeros.
            if ((ZERO_POS_WINS != 0) && (sign_a != sign_b))
                a_ge_b = ~sign_a;
            else
                a_ge_b = 1'b1;
        end else if (sign_a != sign_b) begin
            a_ge_b = ~sign_a;
        end else if (!sign_a) begin
            a_ge_b = (mag_a >= mag_b);
        end else begin
            // Both negative: the smaller magnitude is the larger value.
            a_ge_b = (mag_a <= mag_b);
        end
    end

endmodule

// File: rtl/fmax_reduce.sv
// Streaming fp32 max reducer: folds an in_last-terminated group into its maximum
// and element count. Ports: clk/rst, in_valid/in_ready/in_data/in_last stream in,
// out_valid/out_ready/out_data/out_count stream out. Result registered on the edge
// after the last transfer; input stalls (in_ready=0) while a result is pending.
// Optional FMAX_NAN_EN: any NaN in a group forces the canonical qNaN result.
module fmax_reduce
    import fpu_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int ZERO_POS_WINS = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fmax_state_t      state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;

    logic             take;
    logic             acc_ge_in;
    logic [31:0]      next_acc;
    logic [CNT_W-1:0] next_count;
    logic [31:0]      result;

    // Depends on state only so no combinational path reaches in_ready.
    assign in_ready = (state != ST_DONE);
    assign take     = in_valid && in_ready;

    fmax_cmp #(
        .ZERO_POS_WINS (ZERO_POS_WINS)
    ) u_cmp (
        .a      (acc),
        .b      (in_data),
        .a_ge_b (acc_ge_in)
    );

    // Value the accumulator and counter take if the current operand transfers.
    always_comb begin
        next_acc   = in_data;
        next_count = CNT_ONE;
        if (state == ST_ACCUM) begin
            next_acc   = acc_ge_in ? acc : in_data;
            next_count = (count == CNT_MAX) ? count : count + CNT_ONE;
        end
    end

`ifdef FMAX_NAN_EN
    logic nan_flag;
    logic next_nan;

    // The flag is already clear in IDLE, so OR-ing it in is safe for any state.
    always_comb begin
        next_nan = nan_flag | fp32_is_nan(in_data);
        result   = next_nan ? FP32_QNAN : next_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_flag <= 1'b0;
        end else if (state == ST_DONE) begin
            if (out_ready)
                nan_flag <= 1'b0;
        end else if (take) begin
            nan_flag <= next_nan;
        end
    end
`else
    assign result = next_acc;
`endif

    // Control FSM with registered outputs; the result is captured from the
    // look-ahead values so it appears one edge after the last transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= 32'd0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (take) begin
                        acc   <= next_acc;
                        count <= next_count;
                        if (in_last) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_data  <= result;
                            out_count <= next_count;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    // Outputs hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmax_reduce.sv
// Bench for fmax_reduce: two instances (CNT_W=16/+0 wins, CNT_W=2/zeros tie) share
// one stimulus stream; results are checked against an order-key reference model.
// Directed groups first, then randomized groups with random output backpressure.
module tb_fmax_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_s;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_valid_s;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_data_s;
    logic [15:0] out_count;
    logic [1:0]  out_count_s;

    int n_vec = 0;
    int n_bad = 0;

    bit hold     = 1'b0;
    bit rdy_mode = 1'b1;

    always #5 clk = ~clk;

    fmax_reduce #(.CNT_W(16), .ZERO_POS_WINS(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    fmax_reduce #(.CNT_W(2), .ZERO_POS_WINS(0)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_count(out_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Map fp32 onto an unsigned total order: positives above negatives,
    // negatives reversed. Without +0 preference, both zeros share one key.
    function automatic logic [31:0] ord_key(input logic [31:0] x, input bit zpw);
        if (!zpw && (x[30:0] == 31'd0))
            return 32'h8000_0000;
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] g[$], input bit zpw);
        logic [31:0] best;
        best = g[0];
        for (int i = 1; i < g.size(); i++)
            if (ord_key(g[i], zpw) > ord_key(best, zpw))
                best = g[i];
`ifdef FMAX_NAN_EN
        for (int i = 0; i < g.size(); i++)
            if ((g[i][30:23] == 8'hFF) && (g[i][22:0] != 23'd0))
                best = 32'h7FC0_0000;
`endif
        return best;
    endfunction

    logic [31:0] cur[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_s[$];
    int          exp_n[$];

    bit          prev_last = 1'b0;
    bit          prev_hs   = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] hold_dat;
    logic [15:0] hold_cnt;

    // Monitor/scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            exp_a.delete();
            exp_s.delete();
            exp_n.delete();
            prev_last = 1'b0;
            prev_hs   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("rdy_vs_vld", {31'd0, in_ready}, {31'd0, !out_valid});
            check("pair_vld", {31'd0, out_valid_s}, {31'd0, out_valid});
            check("pair_rdy", {31'd0, in_ready_s}, {31'd0, in_ready});
            if (prev_last)
                check("latency", {31'd0, out_valid}, 32'd1);
            if (prev_hs) begin
                check("one_cycle", {31'd0, out_valid}, 32'd0);
                check("rdy_after", {31'd0, in_ready}, 32'd1);
            end
            if (prev_hold) begin
                check("hold_vld", {31'd0, out_valid}, 32'd1);
                check("hold_dat", out_data, hold_dat);
                check("hold_cnt", {16'd0, out_count}, {16'd0, hold_cnt});
            end
            if (out_valid && out_ready) begin
                if (exp_a.size() == 0) begin
                    check("spurious", 32'd1, 32'd0);
                end else begin
                    int n;
                    n = exp_n.pop_front();
                    check("data", out_data, exp_a.pop_front());
                    check("count", {16'd0, out_count}, (n > 65535) ? 32'd65535 : n);
                    check("sat_data", out_data_s, exp_s.pop_front());
                    check("sat_count", {30'd0, out_count_s}, (n > 3) ? 32'd3 : n);
                end
            end
            prev_hs   = out_valid && out_ready;
            prev_hold = out_valid && !out_ready;
            hold_dat  = out_data;
            hold_cnt  = out_count;
            prev_last = 1'b0;
            if (in_valid && in_ready) begin
                cur.push_back(in_data);
                if (in_last) begin
                    exp_a.push_back(ref_max(cur, 1'b1));
                    exp_s.push_back(ref_max(cur, 1'b0));
                    exp_n.push_back(cur.size());
                    cur.delete();
                    prev_last = 1'b1;
                end
            end
        end
    end

    // Output backpressure driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : (rdy_mode ? 1'b1 : ($urandom_range(0, 2) != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [31:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 8))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'h7F80_0000;
            3: v = 32'hFF80_0000;
            4: v = {v[31], 8'hFF, v[22:1], 1'b1};
            5: v = {v[31], 8'h00, v[22:0]};
            6: v = {v[31], 8'd126 + {6'd0, v[24:23]}, v[22:19], 19'd0};
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_last  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_dat", out_data, 32'd0);
        check("rst_cnt", {16'd0, out_count}, 32'd0);
        check("rst_sat_cnt", {30'd0, out_count_s}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Mixed-sign group.
        push(32'h3F80_0000, 1'b0);
        push(32'h4000_0000, 1'b0);
        push(32'hC040_0000, 1'b1);
        idle(3);

        // All-negative group and both zero orderings.
        push(32'hC040_0000, 1'b0);
        push(32'hBF00_0000, 1'b1);
        push(32'h8000_0000, 1'b0);
        push(32'h0000_0000, 1'b1);
        push(32'h0000_0000, 1'b0);
        push(32'h8000_0000, 1'b1);
        idle(3);

        // Stalled single-element result, then an immediate next group.
        hold = 1'b1;
        idle(1);
        push(32'h7F80_0000, 1'b1);
        repeat (5) @(negedge clk);
        check("stall_vld", {31'd0, out_valid}, 32'd1);
        check("stall_rdy", {31'd0, in_ready}, 32'd0);
        hold = 1'b0;
        push(32'h3F80_0000, 1'b1);
        idle(3);

        // NaN in the middle of a group.
        push(32'h3F80_0000, 1'b0);
        push(32'h7FC0_0001, 1'b0);
        push(32'h4000_0000, 1'b1);
        idle(3);

        // Reset mid-group, then a fresh single-element group.
        push(32'h3F80_0000, 1'b0);
        push(32'h4100_0000, 1'b0);
        pulse_reset();
        push(32'hBF80_0000, 1'b1);
        idle(3);

        // Reset while a result is pending.
        hold = 1'b1;
        idle(1);
        push(32'h4040_0000, 1'b1);
        repeat (2) @(negedge clk);
        pulse_reset();
        hold = 1'b0;
        idle(2);

        // Five elements: saturates the 2-bit counter.
        push(32'h40A0_0000, 1'b0);
        push(32'h3F80_0000, 1'b0);
        push(32'h4120_0000, 1'b0);
        push(32'hC120_0000, 1'b0);
        push(32'h4000_0000, 1'b1);
        idle(3);

        // Randomized groups under random backpressure.
        rdy_mode = 1'b0;
        for (int g = 0; g < 250; g++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                push(rand_val(), (k == len - 1));
                if ($urandom_range(0, 3) == 0)
                    idle($urandom_range(1, 2));
            end
        end

        rdy_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_a.size() == 0)
                break;
            @(posedge clk);
        end
        idle(2);
        check("drain", exp_a.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
